fetch_stage: RTL

Instruction-fetch stage of the 3-stage RV32I core. It sits directly upstream of the IF/ID pipeline register and drives its fetch-side inputs: instruction, PC, PC+4 and the sign-extended immediate. It owns the PC register, a single-outstanding instruction-memory handshake, branch/jump redirect with discard of stale responses, and a one-entry hold buffer for stalls. Empty slots are filled with bubbles (NOP, valid low).

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/imm_gen.sv | 23 ++
 rtl/fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, NOP encoding, immediate formats and fetch FSM states.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} fetch_state_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                      return IMM_S;
            OPC_BRANCH:                     return IMM_B;
            OPC_LUI, OPC_AUIPC:             return IMM_U;
            OPC_JAL:                        return IMM_J;
            default:                        return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extractor; shared by fetch and decode.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (imm_type_of(i_instr[6:0]))
            IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem handshake, redirect with
// stale-response discard, and a one-entry hold buffer for stalls.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned    DW       = 32,
    parameter logic [DW-1:0]  RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic [DW-1:0] instr_f,
    output logic [DW-1:0] pc_f,
    output logic [DW-1:0] pc_plus_4_f,
    output logic [DW-1:0] imm_ext_f,
    output logic          valid_f
);

    fetch_state_e  r_state, w_state_n;
    logic [DW-1:0] r_pc, w_pc_n;
    logic          r_discard, w_discard_n;
    logic [DW-1:0] r_buf, w_buf_n;

    logic          w_rsp, w_valid, w_fire, w_req;
    logic [DW-1:0] w_instr, w_addr, w_pc_inc, w_target;

    assign w_pc_inc = r_pc + DW'(4);
    assign w_target = {redirect_pc_i[DW-1:2], 2'b00};
    assign w_rsp    = (r_state == WAIT) && imem_rvalid_i && !r_discard;

    always_comb begin
        w_valid = 1'b0;
        w_instr = NOP_INSTR;
        if (!redirect_i) begin
            if (w_rsp) begin
                w_valid = 1'b1;
                w_instr = imem_rdata_i;
            end else if (r_state == HOLD) begin
                w_valid = 1'b1;
                w_instr = r_buf;
            end
        end
    end

    assign w_fire = w_valid && !stall_i && !redirect_i;

    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_discard_n = r_discard;
        w_buf_n     = r_buf;
        w_req       = 1'b0;
        w_addr      = r_pc;
        if (redirect_i) begin
            w_pc_n = w_target;
            // With a response still in flight the target must wait for it to drain.
            if (r_state == WAIT && !imem_rvalid_i) begin
                w_discard_n = 1'b1;
            end else begin
                w_req       = 1'b1;
                w_addr      = w_target;
                w_discard_n = 1'b0;
                w_state_n   = WAIT;
            end
        end else begin
            case (r_state)
                BOOT:  w_state_n = ISSUE;
                ISSUE: begin
                    w_req     = 1'b1;
                    w_state_n = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (r_discard) begin
                            w_req       = 1'b1;
                            w_discard_n = 1'b0;
                        end else if (w_fire) begin
                            w_pc_n = w_pc_inc;
                            w_req  = 1'b1;
                            w_addr = w_pc_inc;
                        end else begin
                            w_buf_n   = imem_rdata_i;
                            w_state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_fire) begin
                        w_pc_n    = w_pc_inc;
                        w_req     = 1'b1;
                        w_addr    = w_pc_inc;
                        w_state_n = WAIT;
                    end
                end
                default: w_state_n = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= BOOT;
            r_pc      <= RESET_PC;
            r_discard <= 1'b0;
            r_buf     <= DW'(NOP_INSTR);
        end else begin
            r_state   <= w_state_n;
            r_pc      <= w_pc_n;
            r_discard <= w_discard_n;
            r_buf     <= w_buf_n;
        end
    end

    imm_gen u_imm_gen (
        .i_instr (w_instr),
        .o_imm   (imm_ext_f)
    );

    assign imem_req_o  = w_req;
    assign imem_addr_o = w_addr;
    assign instr_f     = w_instr;
    assign valid_f     = w_valid;
    assign pc_f        = r_pc;
    assign pc_plus_4_f = w_pc_inc;

    a_rvalid_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (r_state == WAIT));

endmodule
